// File: rtl/apb_master_bridge_mc.sv
// APB4 master bridge: valid/ready command port to a multi-slave APB fabric.
// Decodes the slave from the address, adds strobes, PSLVERR and PREADY timeout.
module apb_master_bridge_mc #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SLV_AW     = 12,
  parameter int TIMEOUT    = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [DATA_W/8-1:0]          req_strb,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic                         rsp_timeout,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  output logic [ADDR_W-1:0]            PADDR,
  output logic                         PWRITE,
  output logic [DATA_W-1:0]            PWDATA,
  output logic [DATA_W/8-1:0]          PSTRB,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);

  localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic                write_q, write_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rvld_q, rvld_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rerr_q, rerr_d;
  logic                rto_q, rto_d;

  logic [SEL_W-1:0]    req_idx;
  logic                dec_ok;
  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_ready;
  logic                sel_err;

  assign req_idx = req_addr[SLV_AW+SEL_W-1:SLV_AW];
  assign dec_ok  = int'(req_idx) < NUM_SLAVES;

  // Only the addressed slave's return signals are ever observed
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (int'(idx_q) == k) begin
        sel_rdata = PRDATA[k*DATA_W +: DATA_W];
        sel_ready = PREADY[k];
        sel_err   = PSLVERR[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    write_d = write_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rvld_d  = 1'b0;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    rto_d   = rto_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          strb_d  = req_strb;
          write_d = req_write;
          idx_d   = req_idx;
          if (dec_ok) begin
            state_d = SETUP;
          end else begin
            rvld_d  = 1'b1;
            rdata_d = '0;
            rerr_d  = 1'b1;
            rto_d   = 1'b0;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d = IDLE;
          rvld_d  = 1'b1;
          rerr_d  = sel_err;
          rto_d   = 1'b0;
          rdata_d = (!write_q && !sel_err) ? sel_rdata : '0;
        end else if (TIMEOUT != 0 && int'(cnt_q) == TIMEOUT - 1) begin
          state_d = IDLE;
          rvld_d  = 1'b1;
          rerr_d  = 1'b1;
          rto_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
      rto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      rto_q   <= rto_d;
    end
  end

  always_comb begin
    PSEL = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      PSEL[k] = (state_q != IDLE) && (int'(idx_q) == k);
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign PENABLE     = (state_q == ACCESS);
  assign PADDR       = addr_q;
  assign PWRITE      = write_q;
  assign PWDATA      = wdata_q;
  assign PSTRB       = write_q ? strb_q : '0;
  assign rsp_valid   = rvld_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = rerr_q;
  assign rsp_timeout = rto_q;

endmodule
